// File: rtl/riscv_pkg.sv
// Shared RV32IM decode constants, ALU opcode encoding and the decoded-control bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [4:0]  div_op;
    logic        reg_write;
    logic        alu_src;
    logic        is_branch;
    logic        jal_jump;
    logic        jalr_jump;
    logic        is_load;
    logic        is_store;
    logic        div_start;
    logic        is_div_instruction;
    logic        is_lui;
    logic        is_auipc;
    logic        decoder_illegal;
    logic        cpu_halt;
    logic [2:0]  b_type;
    logic [2:0]  load_type;
    logic [2:0]  store_type;
  } ctrl_t;

  // Register-register and register-immediate ops share one funct3 map;
  // alt selects SUB (funct3 000) or SRA (funct3 101).
  function automatic logic [4:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unassigned opcodes yield zero.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic        [4:0]      shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  // Operation select; arithmetic wraps at XLEN bits.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = a_s >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Combinational branch-condition evaluation on the two register operands.
module branch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_branch,
  input  logic [2:0]      b_type,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            take_branch
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   cond;

  assign rs1_s = rs1_val;
  assign rs2_s = rs2_val;

  // Condition per funct3, gated so non-branches never take.
  always_comb begin
    cond = 1'b0;
    case (b_type)
      F3_BEQ:  cond = (rs1_val == rs2_val);
      F3_BNE:  cond = (rs1_val != rs2_val);
      F3_BLT:  cond = (rs1_s < rs2_s);
      F3_BGE:  cond = (rs1_s >= rs2_s);
      F3_BLTU: cond = (rs1_val < rs2_val);
      F3_BGEU: cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
    take_branch = is_branch && cond;
  end

endmodule

// File: rtl/decoder.sv
// Combinational RV32IM instruction decoder producing the control bundle and immediate.
module decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Flags are raised only on legal paths, so an illegal word leaves every enable at 0.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_MULDIV) begin
          ctrl.is_div_instruction = 1'b1;
          ctrl.div_start          = 1'b1;
          ctrl.div_op             = {2'b00, funct3};
          ctrl.reg_write          = 1'b1;
        end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          ctrl.alu_op    = alu_op_from_f3(funct3, funct7[5] && (funct3 == 3'b000 || funct3 == 3'b101));
          ctrl.reg_write = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ctrl.imm       = imm_i;
        ctrl.alu_op    = alu_op_from_f3(funct3, (funct3 == 3'b101) && instr[30]);
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.imm = imm_i;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
          illegal = 1'b1;
        end else begin
          ctrl.is_load   = 1'b1;
          ctrl.load_type = funct3;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
      end
      OPC_STORE: begin
        ctrl.imm = imm_s;
        if (funct3 > F3_SW) begin
          illegal = 1'b1;
        end else begin
          ctrl.is_store   = 1'b1;
          ctrl.store_type = funct3;
          ctrl.alu_src    = 1'b1;
        end
      end
      OPC_BRANCH: begin
        ctrl.imm = imm_b;
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          illegal = 1'b1;
        end else begin
          ctrl.is_branch = 1'b1;
          ctrl.b_type    = funct3;
        end
      end
      OPC_JAL: begin
        ctrl.imm       = imm_j;
        ctrl.jal_jump  = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl.imm       = imm_i;
        ctrl.jalr_jump = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_LUI: begin
        ctrl.imm       = imm_u;
        ctrl.is_lui    = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm       = imm_u;
        ctrl.is_auipc  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_FENCE: begin
        ctrl.imm = imm_i;
      end
      OPC_SYSTEM: begin
        ctrl.imm      = imm_i;
        ctrl.cpu_halt = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    ctrl.decoder_illegal = illegal;
  end

endmodule

// File: rtl/alu_branch_decoder.sv
// Decode + execute of one RV32IM instruction, registered once at the execute/memory boundary.
module alu_branch_decoder
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic [4:0]      alu_op,
  output logic [4:0]      div_op,
  output logic            reg_write,
  output logic            alu_src,
  output logic            is_branch,
  output logic            jal_jump,
  output logic            jalr_jump,
  output logic            is_load,
  output logic            is_store,
  output logic            div_start,
  output logic            is_div_instruction,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            decoder_illegal,
  output logic            cpu_halt,
  output logic [2:0]      b_type,
  output logic [2:0]      load_type,
  output logic [2:0]      store_type,
  output logic [XLEN-1:0] alu_result,
  output logic            take_branch,
  output logic [XLEN-1:0] pc_target
);

  ctrl_t           dec_p0;
  logic [XLEN-1:0] op_a_p0;
  logic [XLEN-1:0] op_b_p0;
  logic [XLEN-1:0] alu_res_p0;
  logic [XLEN-1:0] jalr_sum_p0;
  logic [XLEN-1:0] target_p0;
  logic            take_p0;

  ctrl_t           ctrl_p1;
  logic [XLEN-1:0] alu_result_p1;
  logic [XLEN-1:0] pc_target_p1;
  logic            take_p1;

  // ---- stage 0: combinational decode and execute ----
  assign rd  = instr[11:7];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  decoder u_decoder (
    .instr (instr),
    .ctrl  (dec_p0)
  );

  assign op_a_p0 = dec_p0.is_auipc ? pc : rs1_val;
  assign op_b_p0 = dec_p0.alu_src ? dec_p0.imm : rs2_val;

  alu #(.XLEN(XLEN)) u_alu (
    .op     (dec_p0.alu_op),
    .a      (op_a_p0),
    .b      (op_b_p0),
    .result (alu_res_p0)
  );

  branch_unit #(.XLEN(XLEN)) u_branch_unit (
    .is_branch   (dec_p0.is_branch),
    .b_type      (dec_p0.b_type),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .take_branch (take_p0)
  );

  // JALR clears bit 0 of the sum; everything else is PC-relative.
  assign jalr_sum_p0 = rs1_val + dec_p0.imm;
  assign target_p0   = dec_p0.jalr_jump ? {jalr_sum_p0[XLEN-1:1], 1'b0} : (pc + dec_p0.imm);

  // ---- stage 1: execute/memory boundary register, held while stalled ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_p1       <= '0;
      alu_result_p1 <= '0;
      pc_target_p1  <= '0;
      take_p1       <= 1'b0;
    end else if (!stall) begin
      ctrl_p1       <= dec_p0;
      alu_result_p1 <= alu_res_p0;
      pc_target_p1  <= target_p0;
      take_p1       <= take_p0;
    end
  end

  assign imm                = ctrl_p1.imm;
  assign alu_op             = ctrl_p1.alu_op;
  assign div_op             = ctrl_p1.div_op;
  assign reg_write          = ctrl_p1.reg_write;
  assign alu_src            = ctrl_p1.alu_src;
  assign is_branch          = ctrl_p1.is_branch;
  assign jal_jump           = ctrl_p1.jal_jump;
  assign jalr_jump          = ctrl_p1.jalr_jump;
  assign is_load            = ctrl_p1.is_load;
  assign is_store           = ctrl_p1.is_store;
  assign div_start          = ctrl_p1.div_start;
  assign is_div_instruction = ctrl_p1.is_div_instruction;
  assign is_lui             = ctrl_p1.is_lui;
  assign is_auipc           = ctrl_p1.is_auipc;
  assign decoder_illegal    = ctrl_p1.decoder_illegal;
  assign cpu_halt           = ctrl_p1.cpu_halt;
  assign b_type             = ctrl_p1.b_type;
  assign load_type          = ctrl_p1.load_type;
  assign store_type         = ctrl_p1.store_type;
  assign alu_result         = alu_result_p1;
  assign pc_target          = pc_target_p1;
  assign take_branch        = take_p1;

endmodule

// File: tb/tb_alu_branch_decoder.sv
// Directed + randomized bench for alu_branch_decoder with an instruction-level reference model.
module tb_alu_branch_decoder;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] instr, pc, rs1_val, rs2_val;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [4:0]  alu_op, div_op;
  logic        reg_write, alu_src, is_branch, jal_jump, jalr_jump, is_load, is_store;
  logic        div_start, is_div_instruction, is_lui, is_auipc, decoder_illegal, cpu_halt;
  logic [2:0]  b_type, load_type, store_type;
  logic [31:0] alu_result;
  logic        take_branch;
  logic [31:0] pc_target;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  alu_branch_decoder #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .instr(instr), .pc(pc),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .alu_op(alu_op), .div_op(div_op), .reg_write(reg_write),
    .alu_src(alu_src), .is_branch(is_branch), .jal_jump(jal_jump),
    .jalr_jump(jalr_jump), .is_load(is_load), .is_store(is_store),
    .div_start(div_start), .is_div_instruction(is_div_instruction),
    .is_lui(is_lui), .is_auipc(is_auipc), .decoder_illegal(decoder_illegal),
    .cpu_halt(cpu_halt), .b_type(b_type), .load_type(load_type),
    .store_type(store_type), .alu_result(alu_result),
    .take_branch(take_branch), .pc_target(pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm, alu_result, pc_target;
    logic [4:0]  alu_op, div_op;
    logic [2:0]  b_type, load_type, store_type;
    logic [12:0] flags;
    logic        take, chk_res, chk_imm;
  } exp_t;

  // Flag order: reg_write alu_src is_branch jal jalr load store div_start is_div lui auipc illegal halt
  function automatic logic [12:0] dut_flags();
    return {reg_write, alu_src, is_branch, jal_jump, jalr_jump, is_load, is_store,
            div_start, is_div_instruction, is_lui, is_auipc, decoder_illegal, cpu_halt};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? 32'($signed(x) >>> sh) : x >> sh;
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return $signed(x) < $signed(y);
      3'd5: return $signed(x) >= $signed(y);
      3'd6: return x < y;
      default: return x >= y;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int code_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic rw, src, br, jl, jr, ld, st, dv, lu, au, ill, hl, alt;
    f3 = ins[14:12];
    f7 = ins[31:25];
    i_imm = 32'($signed(ins) >>> 20);
    s_imm = 32'($signed({ins[31:25], ins[11:7], 20'b0}) >>> 20);
    b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19);
    u_imm = {ins[31:12], 12'b0};
    j_imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11);
    {rw, src, br, jl, jr, ld, st, dv, lu, au, ill, hl, alt} = '0;
    e.imm = 0; e.alu_result = 0; e.alu_op = 0; e.div_op = 0;
    e.b_type = 0; e.load_type = 0; e.store_type = 0; e.take = 0;
    e.chk_res = 0; e.chk_imm = 1;
    case (ins[6:0])
      7'h33: begin
        e.chk_imm = 0;
        if (f7 == 7'h01) begin dv = 1; rw = 1; e.div_op = {2'b0, f3}; end
        else if (f7 == 7'h00 || f7 == 7'h20) begin
          alt = f7[5] && (f3 == 0 || f3 == 5);
          e.alu_op = 5'(code_tab[f3] + int'(alt));
          e.alu_result = ref_alu(f3, alt, a, b); e.chk_res = 1; rw = 1;
        end else ill = 1;
      end
      7'h13: begin
        alt = (f3 == 5) && ins[30];
        e.imm = i_imm; e.alu_op = 5'(code_tab[f3] + int'(alt));
        e.alu_result = ref_alu(f3, alt, a, i_imm); e.chk_res = 1; rw = 1; src = 1;
      end
      7'h03: begin
        e.imm = i_imm;
        if (f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
        else begin ld = 1; rw = 1; src = 1; e.load_type = f3; e.alu_result = a + i_imm; e.chk_res = 1; end
      end
      7'h23: begin
        e.imm = s_imm;
        if (f3 > 2) ill = 1;
        else begin st = 1; src = 1; e.store_type = f3; e.alu_result = a + s_imm; e.chk_res = 1; end
      end
      7'h63: begin
        e.imm = b_imm;
        if (f3 == 2 || f3 == 3) ill = 1;
        else begin br = 1; e.b_type = f3; e.take = ref_branch(f3, a, b); end
      end
      7'h6F: begin e.imm = j_imm; jl = 1; rw = 1; end
      7'h67: begin e.imm = i_imm; jr = 1; rw = 1; src = 1; e.alu_result = a + i_imm; e.chk_res = 1; end
      7'h37: begin e.imm = u_imm; lu = 1; rw = 1; end
      7'h17: begin e.imm = u_imm; au = 1; rw = 1; src = 1; e.alu_result = p + u_imm; e.chk_res = 1; end
      7'h0F: begin e.chk_imm = 0; end
      7'h73: begin e.chk_imm = 0; hl = 1; end
      default: ill = 1;
    endcase
    if (ill) e.chk_imm = 0;
    e.pc_target = jr ? ((a + e.imm) & ~32'd1) : (p + e.imm);
    e.flags = {rw, src, br, jl, jr, ld, st, dv, dv, lu, au, ill, hl};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_model(input string tag, input exp_t e);
    chk({tag, ".flags"},      32'(dut_flags()), 32'(e.flags));
    chk({tag, ".alu_op"},     32'(alu_op), 32'(e.alu_op));
    chk({tag, ".div_op"},     32'(div_op), 32'(e.div_op));
    chk({tag, ".types"},      32'({b_type, load_type, store_type}),
                              32'({e.b_type, e.load_type, e.store_type}));
    chk({tag, ".take"},       32'(take_branch), 32'(e.take));
    if (e.chk_imm) begin
      chk({tag, ".imm"},       imm, e.imm);
      chk({tag, ".pc_target"}, pc_target, e.pc_target);
    end
    if (e.chk_res) chk({tag, ".alu_result"}, alu_result, e.alu_result);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".flags"}, 32'(dut_flags()), 32'd0);
    chk({tag, ".imm"}, imm, 32'd0);
    chk({tag, ".ops"}, 32'({alu_op, div_op, b_type, load_type, store_type, take_branch}), 32'd0);
    chk({tag, ".alu_result"}, alu_result, 32'd0);
    chk({tag, ".pc_target"}, pc_target, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, output exp_t e);
    instr = i; pc = p; rs1_val = a; rs2_val = b;
    e = model(i, p, a, b);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc_tab[12];
    logic [6:0] f7_tab[3];
    logic [31:0] r;
    int sel;
    opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
    f7_tab  = '{7'h00, 7'h20, 7'h01};
    r = $urandom;
    sel = $urandom_range(0, 11);
    r[6:0] = (sel == 11) ? 7'($urandom) : opc_tab[sel];
    if (sel == 0 && $urandom_range(0, 9) != 0) r[31:25] = f7_tab[$urandom_range(0, 2)];
    if (sel == 1 && r[14:12] == 3'd1) r[31:25] = 7'h00;
    if (sel == 1 && r[14:12] == 3'd5) r[31:25] = {1'b0, r[30], 5'b0};
    return r;
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] sp[6];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10};
    return ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
  endfunction

  initial begin
    exp_t ea, eb;
    reset = 1'b0; stall = 1'b0;
    instr = 32'h0050_0093; pc = 0; rs1_val = 0; rs2_val = 0;

    // Reset held across edges
    step(); step();
    check_zero("reset_hold");

    // First instruction after release
    reset = 1'b1;
    apply(32'h0050_0093, 32'h0, 32'h0, 32'h0, ea);
    step();
    chk("addi.rd", 32'(rd), 32'd1);
    chk("addi.imm", imm, 32'd5);
    chk("addi.alu_src", 32'(alu_src), 32'd1);
    chk("addi.reg_write", 32'(reg_write), 32'd1);
    chk("addi.alu_result", alu_result, 32'd5);
    check_model("addi", ea);

    // Mid-run asynchronous reset, no edge needed
    reset = 1'b0;
    #1;
    check_zero("reset_async");
    reset = 1'b1;
    step();
    step();
    chk("addi2.alu_result", alu_result, 32'd5);

    apply(32'h4020_81B3, 32'h0, 32'd3, 32'd5, ea);
    chk("sub.rs1_comb", 32'({rd, rs1, rs2}), 32'({5'd3, 5'd1, 5'd2}));
    step();
    chk("sub.alu_op", 32'(alu_op), 32'd1);
    chk("sub.alu_result", alu_result, 32'hFFFF_FFFE);
    check_model("sub", ea);

    apply(32'h4020_D1B3, 32'h0, 32'h8000_0000, 32'd4, ea); step();
    chk("sra.alu_result", alu_result, 32'hF800_0000);
    check_model("sra", ea);

    apply(32'h0020_B1B3, 32'h0, 32'hFFFF_FFFF, 32'd1, ea); step();
    chk("sltu.alu_result", alu_result, 32'd0);
    check_model("sltu", ea);

    apply(32'hFE20_8CE3, 32'h100, 32'd7, 32'd7, ea); step();
    chk("beq_eq.take", 32'(take_branch), 32'd1);
    chk("beq_eq.pc_target", pc_target, 32'hF8);
    check_model("beq_eq", ea);

    apply(32'hFE20_8CE3, 32'h100, 32'd7, 32'd8, ea); step();
    chk("beq_ne.take", 32'(take_branch), 32'd0);

    apply(32'hFE20_CCE3, 32'h100, 32'hFFFF_FFFF, 32'd1, ea); step();
    chk("blt.take", 32'(take_branch), 32'd1);
    apply(32'hFE20_ECE3, 32'h100, 32'hFFFF_FFFF, 32'd1, ea); step();
    chk("bltu.take", 32'(take_branch), 32'd0);
    check_model("bltu", ea);

    apply(32'h0041_00E7, 32'h200, 32'h1001, 32'd0, ea); step();
    chk("jalr.jalr_jump", 32'(jalr_jump), 32'd1);
    chk("jalr.pc_target", pc_target, 32'h1004);
    check_model("jalr", ea);

    apply(32'h1234_52B7, 32'h0, 32'd0, 32'd0, ea); step();
    chk("lui.is_lui", 32'(is_lui), 32'd1);
    chk("lui.imm", imm, 32'h1234_5000);

    apply(32'h0231_40B3, 32'h0, 32'd9, 32'd3, ea); step();
    chk("div.flags", 32'({is_div_instruction, div_start}), 32'd3);
    chk("div.div_op", 32'(div_op), 32'd4);
    check_model("div", ea);

    apply(32'h0000_0073, 32'h0, 32'd0, 32'd0, ea); step();
    chk("ecall.cpu_halt", 32'(cpu_halt), 32'd1);

    apply(32'h0000_0000, 32'h0, 32'd1, 32'd2, ea); step();
    chk("zero.illegal", 32'(decoder_illegal), 32'd1);
    chk("zero.reg_write", 32'(reg_write), 32'd0);
    check_model("zero", ea);

    // Stall: outputs hold through the stalled cycle, update once released
    apply(32'h0050_0093, 32'h0, 32'd10, 32'd0, ea); step();
    check_model("pre_stall", ea);
    stall = 1'b1;
    apply(32'h4020_81B3, 32'h0, 32'd3, 32'd5, eb); step();
    check_model("stall_edge", ea);
    @(negedge clk);
    check_model("stall_mid", ea);
    stall = 1'b0;
    step();
    check_model("stall_release", eb);

    // Randomized instruction/operand mix
    for (int n = 0; n < 400; n++) begin
      apply(rand_instr(), $urandom, rand_val(), rand_val(), ea);
      stall = ($urandom_range(0, 7) == 0);
      step();
      if (stall) check_model("rand_stall", eb);
      else begin
        check_model("rand", ea);
        eb = ea;
      end
    end
    stall = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_branch_decoder.md
Name: alu_branch_decoder

Overview:
- RV32IM instruction decoder, integer ALU and branch-condition unit in one block, with one output register stage.
- Decodes `instr` combinationally and executes it on supplied operand values. Registers the decoded controls, the ALU result and the branch decision for the execute/memory boundary.
- Multiply/divide is only flagged (`div_op`, `div_start`); the external divider computes it.

Parameters:
- XLEN, 32, datapath width (only 32 supported).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all registered outputs.
- stall  in  1  1 = hold all registered outputs.
- instr  in  32  instruction word.
- pc  in  32  address of instr.
- rs1_val  in  32  forwarded rs1 operand.
- rs2_val  in  32  forwarded rs2 operand.
- rd, rs1, rs2  out  5 each  register fields (combinational).
- imm  out  32  sign-extended immediate (registered).
- alu_op  out  5  ALU opcode (registered).
- div_op  out  5  {2'b0, funct3} for M-extension (registered).
- reg_write, alu_src, is_branch, jal_jump, jalr_jump, is_load, is_store, div_start, is_div_instruction, is_lui, is_auipc, decoder_illegal, cpu_halt  out  1 each  registered controls.
- b_type, load_type, store_type  out  3 each  funct3 copies (registered).
- alu_result  out  32  registered ALU result.
- take_branch  out  1  registered.
- pc_target  out  32  registered branch/jump target.

Behaviour:
- Reset low: every registered output is 0, asynchronously. Removal is synchronous to clk.
- Each rising edge with reset high and stall=0: register the decode and execute results of the current inputs.
- stall=1: all registered outputs hold their values.
- Latency: 1 cycle. rd, rs1 and rs2 are combinational.

Immediate by format:
- I: sign(instr[31:20]).
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.

alu_op codes (5-bit):
- ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- Codes 10–31 give result 0.
- Shift amount is b[4:0]. SLT is signed compare, SLTU unsigned.

Decode by opcode:
- 0110011 OP: funct7=0000000 or 0100000 selects ALU op; alu_src=0, reg_write=1. funct7=0000001 instead sets is_div_instruction=1, div_start=1, div_op=funct3, reg_write=1.
- 0010011 OP-IMM: alu_src=1, reg_write=1. SRAI when instr[30]=1.
- 0000011 LOAD: is_load=1, load_type=funct3, ADD, alu_src=1, reg_write=1.
- 0100011 STORE: is_store=1, store_type=funct3, ADD, alu_src=1.
- 1100011 BRANCH: is_branch=1, b_type=funct3, alu_src=0.
- 1101111 JAL: jal_jump=1, reg_write=1.
- 1100111 JALR: jalr_jump=1, alu_src=1, reg_write=1.
- 0110111 LUI: is_lui=1, reg_write=1.
- 0010111 AUIPC: is_auipc=1, ADD with A=pc, B=imm, reg_write=1.
- 0001111 FENCE: NOP, no flags set.
- 1110011 SYSTEM: cpu_halt=1.
- Any other opcode, an illegal funct7, or an illegal branch/load/store funct3: decoder_illegal=1 and every enable/flag is 0. Illegal funct3 values are branch 010/011, load 011/110/111, store ≥011.
- instr=0 is illegal.
- rd=0 with reg_write=1 is legal.

Execute:
- ALU A = is_auipc ? pc : rs1_val.
- ALU B = alu_src ? imm : rs2_val.
- Branch compare always uses rs1_val vs rs2_val.
- take_branch: BEQ 000 =, BNE 001 ≠, BLT 100 signed <, BGE 101 signed ≥, BLTU 110 unsigned <, BGEU 111 unsigned ≥. It is 0 when is_branch=0; jumps do not set take_branch.
- pc_target = jalr_jump ? ((rs1_val+imm) & ~1) : pc+imm.
- Arithmetic wraps modulo 2^32.

Decomposition:
- Shared package riscv_pkg: opcode constants, ALU_* opcode localparams, funct3 branch/load/store constants.
- Sub-modules:
  - decoder: combinational.
  - alu: combinational.
  - branch_unit: combinational.
  - Output register: in the top level.

Test Plan:
- Reset low mid-run with stall=0 → all outputs 0 immediately; after release, `addi x1,x0,5` (0x00500093) gives rd=1, imm=5, alu_src=1, reg_write=1, alu_result=5 one edge later.
- `sub x3,x1,x2` (0x402081B3), rs1=3, rs2=5 → alu_op=1, alu_result=0xFFFFFFFE. `sra` on rs1=0x80000000, rs2=4 → 0xF8000000. `sltu` on rs1=0xFFFFFFFF, rs2=1 → 0.
- `beq x1,x2,-8` (0xFE208CE3), pc=0x100, rs1=rs2=7 → take_branch=1, pc_target=0xF8. With rs2=8 → take_branch=0. `blt` on rs1=-1, rs2=1 → 1; `bltu` on the same → 0.
- `jalr x1,4(x2)` (0x004100E7), rs1=0x1001 → jalr_jump=1, pc_target=0x1004. `lui x5,0x12345` (0x123452B7) → is_lui=1, imm=0x12345000.
- `div x1,x2,x3` (0x023140B3) → is_div_instruction=1, div_start=1, div_op=4. `ecall` (0x00000073) → cpu_halt=1. 0x00000000 → decoder_illegal=1, reg_write=0.
- stall=1 with a new instr → outputs unchanged for the whole stalled cycle, update on the first edge with stall=0.
